cache_data_array: RTL and testbench
===================================

Name: cache_data_array

Overview:
- Clocked, parametrised L1 cache data store, organised as lines of WORDS_PER_LINE words.
- Provides a word-granular CPU port with byte enables and 1-cycle synchronous read.
- Includes a line-fill sequencer that takes refill data from L2 and an eviction sequencer that streams a victim line to L2.
- Sits beside the tag/state array; the cache controller issues fill/evict commands after the tag lookup.

Parameters:
NUM_OF_LINE, 256, number of cache lines
INDEX_WIDTH, 8, log2(NUM_OF_LINE)
WORDS_PER_LINE, 4, words per line (power of two, >=2)
OFFSET_WIDTH, 2, log2(WORDS_PER_LINE)
DATA_WIDTH, 32, word width in bits (multiple of 8)

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous reset, active-high
cpu_req  in  1  CPU access request
cpu_we  in  1  1=write, 0=read
cpu_index  in  INDEX_WIDTH  line index
cpu_offset  in  OFFSET_WIDTH  word within line
cpu_be  in  DATA_WIDTH/8  byte enables (write only)
cpu_din  in  DATA_WIDTH  write data
cpu_gnt  out  1  request accepted this cycle (combinational)
cpu_dout  out  DATA_WIDTH  read data
cpu_dvalid  out  1  cpu_dout valid (1-cycle pulse)
busy  out  1  fill or evict in progress
fill_start  in  1  begin line refill
fill_index  in  INDEX_WIDTH  line to refill
fill_valid  in  1  refill word present
fill_data  in  DATA_WIDTH  refill word
fill_ready  out  1  refill word accepted
fill_done  out  1  refill complete (1-cycle pulse)
evict_start  in  1  begin line eviction
evict_index  in  INDEX_WIDTH  line to evict
evict_valid  out  1  evict_data valid
evict_data  out  DATA_WIDTH  victim word
evict_ready  in  1  L2 accepts evict_data
evict_done  out  1  eviction complete (1-cycle pulse)

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; counters 0. Array contents are not reset.
- Reset mid-fill or mid-evict: abort immediately; no done pulse; words already written remain.
- FSM states: IDLE, FILL, EVICT. busy = (state != IDLE).
- Start priority in IDLE: evict_start > fill_start > cpu_req. A start signal is ignored outside IDLE.
- Latched index: index latched on start; offset counter cleared.
- cpu_gnt = cpu_req & IDLE & !fill_start & !evict_start. An ungranted request is dropped; the requester must retry.
- Granted read: cpu_dout = word[cpu_index][cpu_offset] and cpu_dvalid=1 on the next cycle. cpu_dout holds its value until the next granted read.
- Granted write: only bytes with cpu_be[i]=1 are updated. No cpu_dvalid. Takes effect for reads granted the following cycle.
- FILL:
  - fill_ready=1 throughout.
  - Each cycle with fill_valid=1 writes fill_data (all bytes) to word[counter], then counter++.
  - On the write of word WORDS_PER_LINE-1: next cycle fill_done=1, state=IDLE, fill_ready=0.
  - Gaps in fill_valid are allowed.
- EVICT:
  - The cycle after start, evict_valid=1 and evict_data=word 0.
  - Handshake when evict_valid & evict_ready: advance to the next word, presented the next cycle. This gives one word per cycle with evict_ready held high.
  - While evict_ready=0, evict_data and evict_valid hold stable.
  - After the handshake of word WORDS_PER_LINE-1: next cycle evict_valid=0, evict_done=1, state=IDLE.
- Done to start: a new command may be started in the same cycle a done pulse is high (FSM is already IDLE).
- Counter width: OFFSET_WIDTH. Wrap-around does not occur; the last-word detect terminates the sequence.
- Memory: synchronous read, one read and one write per cycle. No read/write conflicts arise, since CPU, fill and evict are mutually exclusive.

Decomposition:
- Shared package (define.v): FSM state encodings, `_4B default width, and a line-geometry macro for WORDS_PER_LINE.
- Natural sub-module: cache_line_ram.
  - Byte-enabled, synchronous-read RAM of NUM_OF_LINE*WORDS_PER_LINE words.
  - Address is {index, offset}.
- Top level holds the FSM, counters, muxing and the evict output register.

Test Plan:
- Byte-enabled CPU write: write 0xDEADBEEF to (5,2) with be=1111, then 0x000000AA with be=0001. Read (5,2) -> cpu_dout=0xDEADBEAA with cpu_dvalid exactly 1 cycle after grant.
- Fill with gaps: fill_start index 7, feed 0x10,0x11,(gap),0x12,0x13 -> fill_done 1 cycle after the 4th word. CPU reads of (7,0..3) return 0x10..0x13.
- Eviction with backpressure: evict line 7 with evict_ready toggling 1,0,1,1,0,1 -> 0x10..0x13 delivered in order, data stable while stalled, evict_done after the last handshake, busy low the same cycle.
- Simultaneous events: assert evict_start, fill_start and cpu_req in one cycle -> EVICT entered, cpu_gnt=0, fill ignored. After evict_done, a retried cpu_req is granted.
- Reset mid-fill: rst after 2 of 4 fill words -> next cycle busy=0 and fill_ready=0, no fill_done. Words 0-1 are updated; words 2-3 keep their old values.
- Back-to-back commands: fill_start in the cycle fill_done is high -> second fill accepted and completes normally.

Source files
------------

// File: rtl/cache_data_array_pkg.sv
// Shared definitions for the L1 cache data store: sequencer state encoding,
// default geometry and a small width helper.
package cache_data_array_pkg;

    // Sequencer states. CPU accesses are only served in ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_EVICT = 2'd2
    } state_t;

    localparam int BYTE_WIDTH             = 8;
    localparam int DEFAULT_DATA_WIDTH     = 32;
    localparam int DEFAULT_WORDS_PER_LINE = 4;

    // Number of byte lanes in a word of the given width.
    function automatic int byte_lanes(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/cache_data_array_line_ram.sv
// Byte-enabled word RAM with one write port and one registered read port.
// Each byte lane is its own array so the byte enables map directly onto
// independent block-RAM write enables.
module cache_data_array_line_ram
    import cache_data_array_pkg::*;
#(
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              we,
    input  logic [ADDR_WIDTH-1:0]             waddr,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] wbe,
    input  logic [DATA_WIDTH-1:0]             wdata,
    input  logic                              re,
    input  logic [ADDR_WIDTH-1:0]             raddr,
    output logic [DATA_WIDTH-1:0]             rdata
);

    localparam int LANES = byte_lanes(DATA_WIDTH);

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [BYTE_WIDTH-1:0] mem [DEPTH];
            logic [BYTE_WIDTH-1:0] rdata_reg;

            // Per-lane write under its byte enable; read register only loads
            // when a read is requested so the output holds otherwise.
            always_ff @(posedge clk) begin
                if (we && wbe[gi]) begin
                    mem[waddr] <= wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
                end
                if (re) begin
                    rdata_reg <= mem[raddr];
                end
            end

            assign rdata[gi*BYTE_WIDTH +: BYTE_WIDTH] = rdata_reg;
        end
    endgenerate

endmodule

// File: rtl/cache_data_array.sv
// L1 cache data store: CPU word port with byte enables, line-fill sequencer
// fed from L2 and eviction sequencer streaming a victim line back to L2.
module cache_data_array
    import cache_data_array_pkg::*;
#(
    parameter int NUM_OF_LINE    = 256,
    parameter int INDEX_WIDTH    = 8,
    parameter int WORDS_PER_LINE = DEFAULT_WORDS_PER_LINE,
    parameter int OFFSET_WIDTH   = 2,
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH
) (
    input  logic                              clk,
    input  logic                              rst,
    // CPU port
    input  logic                              cpu_req,
    input  logic                              cpu_we,
    input  logic [INDEX_WIDTH-1:0]            cpu_index,
    input  logic [OFFSET_WIDTH-1:0]           cpu_offset,
    input  logic [byte_lanes(DATA_WIDTH)-1:0] cpu_be,
    input  logic [DATA_WIDTH-1:0]             cpu_din,
    output logic                              cpu_gnt,
    output logic [DATA_WIDTH-1:0]             cpu_dout,
    output logic                              cpu_dvalid,
    output logic                              busy,
    // Line fill from L2
    input  logic                              fill_start,
    input  logic [INDEX_WIDTH-1:0]            fill_index,
    input  logic                              fill_valid,
    input  logic [DATA_WIDTH-1:0]             fill_data,
    output logic                              fill_ready,
    output logic                              fill_done,
    // Victim eviction to L2
    input  logic                              evict_start,
    input  logic [INDEX_WIDTH-1:0]            evict_index,
    output logic                              evict_valid,
    output logic [DATA_WIDTH-1:0]             evict_data,
    input  logic                              evict_ready,
    output logic                              evict_done
);

    localparam int BE_WIDTH   = byte_lanes(DATA_WIDTH);
    localparam int ADDR_WIDTH = INDEX_WIDTH + OFFSET_WIDTH;
    localparam int DEPTH      = NUM_OF_LINE * WORDS_PER_LINE;
    localparam logic [OFFSET_WIDTH-1:0] LAST_OFFSET = OFFSET_WIDTH'(WORDS_PER_LINE - 1);

    state_t                  state_reg, state_next;
    logic [OFFSET_WIDTH-1:0] cnt_reg, cnt_next;
    logic [OFFSET_WIDTH-1:0] cnt_inc;
    logic [INDEX_WIDTH-1:0]  line_reg, line_next;
    logic                    cpu_dvalid_reg, cpu_dvalid_next;
    logic                    fill_done_reg, fill_done_next;
    logic                    evict_done_reg, evict_done_next;
    logic [DATA_WIDTH-1:0]   cpu_hold_reg;
    logic                    grant;

    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_waddr;
    logic [BE_WIDTH-1:0]     ram_wbe;
    logic [DATA_WIDTH-1:0]   ram_wdata;
    logic                    ram_re;
    logic [ADDR_WIDTH-1:0]   ram_raddr;
    logic [DATA_WIDTH-1:0]   ram_rdata;

    assign cnt_inc = cnt_reg + 1'b1;

    cache_data_array_line_ram #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wbe   (ram_wbe),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    // Next-state, counter and RAM port steering for the sequencer.
    always_comb begin
        state_next      = state_reg;
        cnt_next        = cnt_reg;
        line_next       = line_reg;
        cpu_dvalid_next = 1'b0;
        fill_done_next  = 1'b0;
        evict_done_next = 1'b0;
        grant           = 1'b0;
        ram_we          = 1'b0;
        ram_waddr       = {line_reg, cnt_reg};
        ram_wbe         = '1;
        ram_wdata       = fill_data;
        ram_re          = 1'b0;
        ram_raddr       = {line_reg, cnt_reg};

        unique case (state_reg)
            ST_IDLE: begin
                if (evict_start) begin
                    // Fetch word 0 now so it is on evict_data next cycle.
                    state_next = ST_EVICT;
                    line_next  = evict_index;
                    cnt_next   = '0;
                    ram_re     = 1'b1;
                    ram_raddr  = {evict_index, {OFFSET_WIDTH{1'b0}}};
                end else if (fill_start) begin
                    state_next = ST_FILL;
                    line_next  = fill_index;
                    cnt_next   = '0;
                end else if (cpu_req) begin
                    grant = 1'b1;
                    if (cpu_we) begin
                        ram_we    = 1'b1;
                        ram_waddr = {cpu_index, cpu_offset};
                        ram_wbe   = cpu_be;
                        ram_wdata = cpu_din;
                    end else begin
                        ram_re          = 1'b1;
                        ram_raddr       = {cpu_index, cpu_offset};
                        cpu_dvalid_next = 1'b1;
                    end
                end
            end
            ST_FILL: begin
                if (fill_valid) begin
                    ram_we = 1'b1;
                    if (cnt_reg == LAST_OFFSET) begin
                        state_next     = ST_IDLE;
                        fill_done_next = 1'b1;
                        cnt_next       = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end
            end
            ST_EVICT: begin
                // evict_valid is high for the whole state, so ready alone
                // completes a handshake. No read on a stall keeps data stable.
                if (evict_ready) begin
                    if (cnt_reg == LAST_OFFSET) begin
                        state_next      = ST_IDLE;
                        evict_done_next = 1'b1;
                        cnt_next        = '0;
                    end else begin
                        cnt_next  = cnt_inc;
                        ram_re    = 1'b1;
                        ram_raddr = {line_reg, cnt_inc};
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Reset aborts everything, including any access in the reset cycle.
        if (rst) begin
            grant  = 1'b0;
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // State, counter, latched index, pulse flags and CPU read-data hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            line_reg       <= '0;
            cpu_dvalid_reg <= 1'b0;
            fill_done_reg  <= 1'b0;
            evict_done_reg <= 1'b0;
            cpu_hold_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            line_reg       <= line_next;
            cpu_dvalid_reg <= cpu_dvalid_next;
            fill_done_reg  <= fill_done_next;
            evict_done_reg <= evict_done_next;
            if (cpu_dvalid_reg) begin
                cpu_hold_reg <= ram_rdata;
            end
        end
    end

    // The RAM read register is shared by CPU reads and eviction, so the CPU
    // sees it only in its valid cycle and a held copy afterwards.
    assign cpu_gnt     = grant;
    assign cpu_dvalid  = cpu_dvalid_reg;
    assign cpu_dout    = cpu_dvalid_reg ? ram_rdata : cpu_hold_reg;
    assign busy        = (state_reg != ST_IDLE);
    assign fill_ready  = (state_reg == ST_FILL);
    assign fill_done   = fill_done_reg;
    assign evict_valid = (state_reg == ST_EVICT);
    assign evict_data  = evict_valid ? ram_rdata : '0;
    assign evict_done  = evict_done_reg;

endmodule

// File: tb/tb_cache_data_array.sv
// Directed bench for cache_data_array: table of CPU accesses plus
// hand-written fill / evict / priority / reset / back-to-back sequences.
module tb_cache_data_array;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [7:0]  cpu_index;
    logic [1:0]  cpu_offset;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_din;
    logic        cpu_gnt;
    logic [31:0] cpu_dout;
    logic        cpu_dvalid, busy;
    logic        fill_start, fill_valid, fill_ready, fill_done;
    logic [7:0]  fill_index;
    logic [31:0] fill_data;
    logic        evict_start, evict_valid, evict_ready, evict_done;
    logic [7:0]  evict_index;
    logic [31:0] evict_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] last_rd = 32'h0;

    typedef struct {
        bit          we;
        logic [7:0]  idx;
        logic [1:0]  off;
        logic [3:0]  be;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    cache_data_array dut (
        .clk         (clk),
        .rst         (rst),
        .cpu_req     (cpu_req),
        .cpu_we      (cpu_we),
        .cpu_index   (cpu_index),
        .cpu_offset  (cpu_offset),
        .cpu_be      (cpu_be),
        .cpu_din     (cpu_din),
        .cpu_gnt     (cpu_gnt),
        .cpu_dout    (cpu_dout),
        .cpu_dvalid  (cpu_dvalid),
        .busy        (busy),
        .fill_start  (fill_start),
        .fill_index  (fill_index),
        .fill_valid  (fill_valid),
        .fill_data   (fill_data),
        .fill_ready  (fill_ready),
        .fill_done   (fill_done),
        .evict_start (evict_start),
        .evict_index (evict_index),
        .evict_valid (evict_valid),
        .evict_data  (evict_data),
        .evict_ready (evict_ready),
        .evict_done  (evict_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // One granted CPU access starting in the current cycle; checks grant,
    // read latency, single-cycle dvalid and that cpu_dout holds afterwards.
    task automatic cpu_access(input bit we, input logic [7:0] idx, input logic [1:0] off,
                              input logic [3:0] be, input logic [31:0] din, input logic [31:0] exp);
        cpu_req = 1'b1; cpu_we = we; cpu_index = idx; cpu_offset = off; cpu_be = be; cpu_din = din;
        #1;
        chk("cpu_gnt", {31'b0, cpu_gnt}, 32'd1);
        tick;
        cpu_req = 1'b0; cpu_we = 1'b0;
        if (!we) begin
            chk("rd_dvalid", {31'b0, cpu_dvalid}, 32'd1);
            chk("rd_dout", cpu_dout, exp);
            last_rd = exp;
        end else begin
            chk("wr_no_dvalid", {31'b0, cpu_dvalid}, 32'd0);
        end
        tick;
        chk("dvalid_pulse", {31'b0, cpu_dvalid}, 32'd0);
        chk("dout_hold", cpu_dout, last_rd);
        $display("cpu %s idx=%0d off=%0d be=%b din=%h dout=%h", we ? "WR" : "RD", idx, off, be, din, cpu_dout);
    endtask

    task automatic fill_begin(input logic [7:0] idx);
        fill_index = idx; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        chk("fill_busy", {31'b0, busy}, 32'd1);
        chk("fill_ready_on", {31'b0, fill_ready}, 32'd1);
    endtask

    // Feeds four consecutive words; returns in the fill_done cycle.
    task automatic fill_words(input logic [31:0] base);
        for (int i = 0; i < 4; i++) begin
            fill_valid = 1'b1; fill_data = base + 32'(i);
            chk("fill_no_done", {31'b0, fill_done}, 32'd0);
            tick;
        end
        fill_valid = 1'b0;
        chk("fill_done", {31'b0, fill_done}, 32'd1);
        chk("fill_idle", {31'b0, busy}, 32'd0);
        $display("fill line=%0d base=%h done=%0b", fill_index, base, fill_done);
    endtask

    initial begin
        bit          rp[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        bit          fv[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] fd[5]  = '{32'h10, 32'h11, 32'h0, 32'h12, 32'h13};
        int          widx;

        vecs[0]  = '{1'b1, 8'd5,   2'd2, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[1]  = '{1'b1, 8'd5,   2'd2, 4'b0001, 32'h000000AA, 32'h0};
        vecs[2]  = '{1'b0, 8'd5,   2'd2, 4'b0000, 32'h0,        32'hDEADBEAA};
        vecs[3]  = '{1'b1, 8'd5,   2'd3, 4'b1111, 32'h12345678, 32'h0};
        vecs[4]  = '{1'b1, 8'd5,   2'd3, 4'b1010, 32'hAABBCCDD, 32'h0};
        vecs[5]  = '{1'b0, 8'd5,   2'd3, 4'b0000, 32'h0,        32'hAA34CC78};
        vecs[6]  = '{1'b0, 8'd5,   2'd2, 4'b0000, 32'h0,        32'hDEADBEAA};
        vecs[7]  = '{1'b1, 8'd255, 2'd3, 4'b1111, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{1'b0, 8'd255, 2'd3, 4'b0000, 32'h0,        32'hCAFEF00D};
        vecs[9]  = '{1'b1, 8'd0,   2'd0, 4'b1111, 32'h01020304, 32'h0};
        vecs[10] = '{1'b1, 8'd0,   2'd0, 4'b0000, 32'hFFFFFFFF, 32'h0};

        rst = 1'b1; cpu_req = 0; cpu_we = 0; cpu_index = 0; cpu_offset = 0; cpu_be = 0; cpu_din = 0;
        fill_start = 0; fill_index = 0; fill_valid = 0; fill_data = 0;
        evict_start = 0; evict_index = 0; evict_ready = 0;

        // Reset state
        tick; tick; tick;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_dvalid", {31'b0, cpu_dvalid}, 32'd0);
        chk("rst_dout", cpu_dout, 32'd0);
        chk("rst_fill_ready", {31'b0, fill_ready}, 32'd0);
        chk("rst_fill_done", {31'b0, fill_done}, 32'd0);
        chk("rst_evict_valid", {31'b0, evict_valid}, 32'd0);
        chk("rst_evict_data", evict_data, 32'd0);
        chk("rst_evict_done", {31'b0, evict_done}, 32'd0);
        rst = 1'b0;
        tick;

        // CPU access table
        for (int i = 0; i < 11; i++) begin
            cpu_access(vecs[i].we, vecs[i].idx, vecs[i].off, vecs[i].be, vecs[i].din, vecs[i].exp);
        end
        cpu_access(1'b0, 8'd0, 2'd0, 4'b0, 32'h0, 32'h01020304);

        // Fill line 7 with a gap in fill_valid
        fill_begin(8'd7);
        for (int i = 0; i < 5; i++) begin
            fill_valid = fv[i]; fill_data = fd[i];
            chk("gap_no_done", {31'b0, fill_done}, 32'd0);
            chk("gap_ready", {31'b0, fill_ready}, 32'd1);
            tick;
        end
        fill_valid = 1'b0;
        chk("gap_done", {31'b0, fill_done}, 32'd1);
        chk("gap_idle", {31'b0, busy}, 32'd0);
        chk("gap_ready_off", {31'b0, fill_ready}, 32'd0);
        $display("fill line=7 with gap done=%0b", fill_done);
        tick;
        chk("gap_done_pulse", {31'b0, fill_done}, 32'd0);
        for (int i = 0; i < 4; i++) cpu_access(1'b0, 8'd7, 2'(i), 4'b0, 32'h0, 32'h10 + 32'(i));

        // Eviction of line 7 with backpressure
        evict_index = 8'd7; evict_start = 1'b1;
        tick;
        evict_start = 1'b0;
        widx = 0;
        for (int i = 0; i < 6; i++) begin
            evict_ready = rp[i];
            chk("ev_valid", {31'b0, evict_valid}, 32'd1);
            chk("ev_data", evict_data, 32'h10 + 32'(widx));
            chk("ev_no_done", {31'b0, evict_done}, 32'd0);
            $display("evict beat %0d ready=%0b data=%h", i, rp[i], evict_data);
            tick;
            if (rp[i]) widx++;
        end
        evict_ready = 1'b0;
        chk("ev_valid_off", {31'b0, evict_valid}, 32'd0);
        chk("ev_done", {31'b0, evict_done}, 32'd1);
        chk("ev_idle", {31'b0, busy}, 32'd0);
        tick;
        chk("ev_done_pulse", {31'b0, evict_done}, 32'd0);

        // Simultaneous evict_start, fill_start and cpu_req
        evict_index = 8'd7; evict_start = 1'b1;
        fill_index = 8'd9; fill_start = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_index = 8'd7; cpu_offset = 2'd1;
        #1;
        chk("sim_no_gnt", {31'b0, cpu_gnt}, 32'd0);
        tick;
        evict_start = 1'b0; fill_start = 1'b0; cpu_req = 1'b0;
        chk("sim_busy", {31'b0, busy}, 32'd1);
        chk("sim_evict", {31'b0, evict_valid}, 32'd1);
        chk("sim_no_fill", {31'b0, fill_ready}, 32'd0);
        chk("sim_no_dvalid", {31'b0, cpu_dvalid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            evict_ready = 1'b1;
            chk("sim_ev_data", evict_data, 32'h10 + 32'(i));
            chk("sim_dout_hold", cpu_dout, last_rd);
            tick;
        end
        evict_ready = 1'b0;
        chk("sim_ev_done", {31'b0, evict_done}, 32'd1);
        $display("simultaneous start: evict done=%0b, retrying cpu read", evict_done);
        cpu_access(1'b0, 8'd7, 2'd1, 4'b0, 32'h0, 32'h11);

        // Reset in the middle of a fill of line 7
        fill_begin(8'd7);
        fill_valid = 1'b1; fill_data = 32'hA0; tick;
        fill_valid = 1'b1; fill_data = 32'hA1; tick;
        fill_valid = 1'b0; rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("mid_busy", {31'b0, busy}, 32'd0);
        chk("mid_ready", {31'b0, fill_ready}, 32'd0);
        chk("mid_no_done", {31'b0, fill_done}, 32'd0);
        chk("mid_dout", cpu_dout, 32'd0);
        last_rd = 32'h0;
        tick;
        chk("mid_no_done2", {31'b0, fill_done}, 32'd0);
        $display("reset mid-fill line=7 busy=%0b", busy);
        cpu_access(1'b0, 8'd7, 2'd0, 4'b0, 32'h0, 32'hA0);
        cpu_access(1'b0, 8'd7, 2'd1, 4'b0, 32'h0, 32'hA1);
        cpu_access(1'b0, 8'd7, 2'd2, 4'b0, 32'h0, 32'h12);
        cpu_access(1'b0, 8'd7, 2'd3, 4'b0, 32'h0, 32'h13);

        // Back-to-back fills: second start in the fill_done cycle
        fill_begin(8'd3);
        fill_words(32'h30);
        fill_index = 8'd4; fill_start = 1'b1;
        tick;
        fill_start = 1'b0;
        chk("b2b_busy", {31'b0, busy}, 32'd1);
        chk("b2b_ready", {31'b0, fill_ready}, 32'd1);
        fill_words(32'h40);
        tick;
        cpu_access(1'b0, 8'd3, 2'd0, 4'b0, 32'h0, 32'h30);
        cpu_access(1'b0, 8'd3, 2'd3, 4'b0, 32'h0, 32'h33);
        cpu_access(1'b0, 8'd4, 2'd0, 4'b0, 32'h0, 32'h40);
        cpu_access(1'b0, 8'd4, 2'd3, 4'b0, 32'h0, 32'h43);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
